// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Purpose  : Frame parser behind a UART receiver. Accepts the byte stream
//            [SOF][ADDR][LEN][PAYLOAD x LEN][CSUM], buffers the payload,
//            verifies the 8-bit two's-complement checksum and, on a good
//            frame, drains the payload as a burst of register writes over a
//            valid/ready port with incrementing (wrapping) addresses.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            sample_tick       - 16x baud tick, drives the inter-byte timeout
//            rx_byte, rx_valid - received byte and its 1-cycle strobe
//            wr_en/wr_addr/wr_data/wr_ready - write request port
//            frame_done, frame_err, overrun - 1-cycle status pulses
//            err_code          - last error (1 LEN, 2 checksum, 3 timeout)
//            busy              - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int                   DATA_BITS     = 8,
    parameter logic [DATA_BITS-1:0] SOF           = 8'hA5,
    parameter int                   MAX_LEN       = 16,
    parameter int                   TIMEOUT_TICKS = 640
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic [DATA_BITS-1:0] rx_byte,
    input  logic                 rx_valid,
    output logic                 wr_en,
    output logic [7:0]           wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_ready,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 overrun,
    output logic                 busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_TICKS);

    localparam logic [DATA_BITS-1:0] C_MAX_LEN     = DATA_BITS'(MAX_LEN);
    localparam logic [CNT_W-1:0]     C_TO_LAST     = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [1:0]           C_ERR_LEN     = 2'd1;
    localparam logic [1:0]           C_ERR_CSUM    = 2'd2;
    localparam logic [1:0]           C_ERR_TIMEOUT = 2'd3;

    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_ADDR    = 3'd1;
    localparam logic [2:0] C_LEN     = 3'd2;
    localparam logic [2:0] C_PAYLOAD = 3'd3;
    localparam logic [2:0] C_CSUM    = 3'd4;
    localparam logic [2:0] C_DRAIN   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [7:0]           addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] buf_q [MAX_LEN];
    logic [DATA_BITS-1:0] buf_d [MAX_LEN];

    logic                 wr_en_q, wr_en_d;
    logic [7:0]           wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic [LEN_W-1:0]     w_idx_next;
    logic                 w_last;
    logic [DATA_BITS-1:0] w_sum_next;

    // idx_q is shared: payload write pointer while receiving, read pointer
    // while draining. w_last marks the final byte in either role.
    assign w_idx_next = idx_q + LEN_W'(1);
    assign w_last     = (idx_q == (len_q - LEN_W'(1)));
    assign w_sum_next = sum_q + rx_byte;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        err_code_d   = err_code_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            C_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_valid && (rx_byte == SOF)) begin
                    state_d = C_ADDR;
                end
            end

            C_ADDR, C_LEN, C_PAYLOAD, C_CSUM: begin
                // A byte always takes priority over a coincident terminal tick.
                if (rx_valid) begin
                    cnt_d = '0;
                    case (state_q)
                        C_ADDR: begin
                            addr_d  = 8'(rx_byte);
                            sum_d   = rx_byte;
                            state_d = C_LEN;
                        end
                        C_LEN: begin
                            if ((rx_byte != '0) && (rx_byte <= C_MAX_LEN)) begin
                                len_d   = rx_byte[LEN_W-1:0];
                                sum_d   = w_sum_next;
                                idx_d   = '0;
                                state_d = C_PAYLOAD;
                            end else begin
                                err_code_d  = C_ERR_LEN;
                                frame_err_d = 1'b1;
                                state_d     = C_IDLE;
                            end
                        end
                        C_PAYLOAD: begin
                            buf_d[idx_q[IDX_W-1:0]] = rx_byte;
                            sum_d = w_sum_next;
                            if (w_last) begin
                                idx_d   = '0;
                                state_d = C_CSUM;
                            end else begin
                                idx_d = w_idx_next;
                            end
                        end
                        default: begin
                            // Checksum byte: the running sum must wrap to zero.
                            // The first write is presented straight away.
                            if (w_sum_next == '0) begin
                                idx_d     = '0;
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = buf_q[0];
                                state_d   = C_DRAIN;
                            end else begin
                                err_code_d  = C_ERR_CSUM;
                                frame_err_d = 1'b1;
                                state_d     = C_IDLE;
                            end
                        end
                    endcase
                end else if (sample_tick) begin
                    if (cnt_q == C_TO_LAST) begin
                        cnt_d       = '0;
                        err_code_d  = C_ERR_TIMEOUT;
                        frame_err_d = 1'b1;
                        state_d     = C_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            C_DRAIN: begin
                cnt_d = '0;
                // Incoming bytes cannot be parsed while the buffer is in use.
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (wr_en_q && wr_ready) begin
                    if (w_last) begin
                        wr_en_d      = 1'b0;
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                        state_d      = C_IDLE;
                    end else begin
                        idx_d     = w_idx_next;
                        wr_addr_d = addr_q + 8'(w_idx_next);
                        wr_data_d = buf_q[w_idx_next[IDX_W-1:0]];
                    end
                end
            end

            default: begin
                state_d = C_IDLE;
            end
        endcase

        busy_d = (state_d != C_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= C_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            buf_q        <= '{default: '0};
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Purpose  : Self-checking bench for uart_rx_frame_ctrl. A frame-level
//            reference model turns each driven byte/tick into expected write,
//            done and error events; a monitor compares DUT activity in order.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         MAX_LEN = 16;
    localparam int         TO      = 640;

    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_ready = 1'b0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .DATA_BITS     (8),
        .SOF           (SOF),
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .overrun     (overrun),
        .busy        (busy)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   ovr_exp  = 0;
    bit   mon_en   = 1'b0;
    int   rmode    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // ---------------- reference model (frame level) ----------------
    bit         m_in = 1'b0;
    byte_q_t    m_fb;
    int         m_ticks = 0;
    logic [1:0] m_err = 2'd0;

    task automatic push(input int k, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic m_error(input logic [1:0] code);
        m_err = code;
        push(K_ERR, 8'h00, {6'd0, code});
        m_in = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        int len;
        int sum;
        m_ticks = 0;
        if (!m_in) begin
            if (b == SOF) begin
                m_in = 1'b1;
                m_fb.delete();
            end
        end else begin
            m_fb.push_back(b);
            len = (m_fb.size() >= 2) ? int'(m_fb[1]) : 0;
            if (m_fb.size() == 2) begin
                if (len < 1 || len > MAX_LEN) m_error(2'd1);
            end else if (m_fb.size() == len + 3) begin
                sum = 0;
                foreach (m_fb[i]) sum += int'(m_fb[i]);
                if (sum % 256 == 0) begin
                    for (int i = 0; i < len; i++)
                        push(K_WR, 8'((int'(m_fb[0]) + i) % 256), m_fb[2 + i]);
                    push(K_DONE, 8'h00, {6'd0, m_err});
                    m_in = 1'b0;
                end else begin
                    m_error(2'd2);
                end
            end
        end
    endtask

    task automatic m_tick();
        if (m_in) begin
            m_ticks++;
            if (m_ticks == TO) m_error(2'd3);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit v, input logic [7:0] b, input bit t);
        @(posedge clk);
        #1;
        rx_valid    = v;
        rx_byte     = b;
        sample_tick = t;
        if (v) m_byte(b);
        else if (t) m_tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit twb);
        for (int i = 0; i < gap; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, b, twb);
        cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input byte_q_t f, input int gapmax);
        foreach (f[i]) send_byte(f[i], $urandom_range(0, gapmax), ($urandom_range(0, 3) == 0));
    endtask

    function automatic logic [7:0] csum_of(input byte_q_t f);
        logic [7:0] s = 8'h00;
        for (int i = 1; i < f.size(); i++) s = s + f[i];
        return 8'h00 - s;
    endfunction

    task automatic mk_frame(output byte_q_t f, input logic [7:0] addr, input int len, input bit good);
        byte_q_t q;
        logic [7:0] b;
        q.push_back(SOF);
        q.push_back(addr);
        q.push_back(8'(len));
        if (len >= 1 && len <= MAX_LEN) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                q.push_back(b);
            end
            b = csum_of(q);
            if (!good) b = b ^ 8'($urandom_range(1, 255));
            q.push_back(b);
        end
        f = q;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        if (m_in) for (int i = 0; i < TO; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now({name, "_idle"});
        repeat (2) @(negedge clk);
        chk({name, "_pending_events"}, exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_wr_en"}, wr_en, 0);
        chk({name, "_wr_addr"}, wr_addr, 0);
        chk({name, "_wr_data"}, wr_data, 0);
        chk({name, "_frame_done"}, frame_done, 0);
        chk({name, "_frame_err"}, frame_err, 0);
        chk({name, "_err_code"}, err_code, 0);
        chk({name, "_overrun"}, overrun, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    // ---------------- write-ready generator ----------------
    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: wr_ready = 1'b1;
                1: wr_ready = 1'($urandom_range(0, 1));
                2: begin
                    rcnt     = (rcnt == 5) ? 0 : rcnt + 1;
                    wr_ready = (rcnt == 5);
                end
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic pop_exp(output exp_t e, output bit ok, input string what);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_%s: got event expected none", what);
            e.kind = -1; e.a = 8'h00; e.d = 8'h00;
            ok = 1'b0;
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_a = 8'h00;
        logic [7:0] prev_d = 8'h00;
        exp_t       e;
        bit         ok;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("hold_wr_en", wr_en, 1);
                    chk("hold_wr_addr", wr_addr, prev_a);
                    chk("hold_wr_data", wr_data, prev_d);
                end
                if (frame_done || frame_err)
                    chk("done_err_exclusive", frame_done & frame_err, 0);
                if (wr_en && wr_ready) begin
                    pop_exp(e, ok, "write");
                    if (ok) begin
                        chk("write_kind", e.kind, K_WR);
                        chk("wr_addr", wr_addr, e.a);
                        chk("wr_data", wr_data, e.d);
                    end
                end
                if (frame_done) begin
                    pop_exp(e, ok, "done");
                    if (ok) begin
                        chk("done_kind", e.kind, K_DONE);
                        chk("done_wr_en_low", wr_en, 0);
                        chk("done_err_code", err_code, e.d);
                    end
                end
                if (frame_err) begin
                    pop_exp(e, ok, "err");
                    if (ok) begin
                        chk("err_kind", e.kind, K_ERR);
                        chk("err_code", err_code, e.d);
                        chk("err_busy_low", busy, 0);
                    end
                end
                if (overrun) begin
                    chk("overrun_expected", (ovr_exp > 0), 1);
                    if (ovr_exp > 0) ovr_exp--;
                end
                prev_stall = !rst && wr_en && !wr_ready;
                prev_a     = wr_addr;
                prev_d     = wr_data;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        byte_q_t f;
        int      n;
        int      k;
        int      kind;
        int      len;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        mon_en = 1'b1;
        rmode  = 0;

        // Basic good frame
        f = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_frame(f, 0);
        wait_idle("good");
        chk("good_err_code", err_code, 0);

        // Address wrap past 0xFF
        f = '{8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33};
        f.push_back(csum_of(f));
        send_frame(f, 0);
        wait_idle("wrap");

        // Bad checksum
        f = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
        send_frame(f, 0);
        wait_idle("bad_csum");
        chk("bad_csum_err_code", err_code, 2);

        // LEN boundaries 0 and MAX_LEN+1, then recovery
        f = '{8'hA5, 8'h10, 8'h00};
        send_frame(f, 0);
        wait_idle("len0");
        f = '{8'hA5, 8'h10, 8'h11};
        send_frame(f, 0);
        wait_idle("len17");
        chk("len_err_code", err_code, 1);
        f = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_frame(f, 0);
        wait_idle("after_len");

        // Timeout after exactly TO ticks of silence
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h10, 0, 1'b0);
        for (int i = 0; i < TO; i++) cyc(1'b0, 8'h00, 1'b1);
        wait_idle("timeout");
        chk("timeout_err_code", err_code, 3);

        // TO-1 ticks keep the frame alive, also with a tick on the byte cycle
        send_byte(8'hA5, 0, 1'b0);
        send_byte(8'h10, 0, 1'b0);
        send_byte(8'h03, TO - 1, 1'b0);
        send_byte(8'h11, TO - 1, 1'b1);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b0);
        send_byte(8'h87, 0, 1'b0);
        wait_idle("keepalive");

        // Slow writes, injected byte mid-drain, then reset mid-drain
        rmode = 2;
        mk_frame(f, 8'h40, 6, 1'b1);
        send_frame(f, 0);
        n = 0;
        @(negedge clk);
        while (!wr_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("drain_start");
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_byte  = 8'h5A;
        ovr_exp++;
        cyc(1'b0, 8'h00, 1'b0);
        n = 0;
        while (exp_q.size() > 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("slow_writes");
        rmode = 3;
        repeat (3) @(negedge clk);
        chk("overrun_seen", ovr_exp, 0);
        chk("mid_drain_wr_en", wr_en, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_in  = 1'b0;
        m_err = 2'd0;
        @(negedge clk);
        chk_all_zero("rst_mid_drain");
        repeat (5) @(negedge clk);

        // Randomized frames
        for (int it = 0; it < 150; it++) begin
            rmode = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, 255);
                send_byte((k == 8'hA5) ? 8'h5A : 8'(k), $urandom_range(0, 3), 1'b0);
            end
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, MAX_LEN);
            if (kind == 0) begin
                mk_frame(f, 8'($urandom_range(0, 255)), len, 1'b0);
                send_frame(f, 3);
            end else if (kind == 1) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                mk_frame(f, 8'($urandom_range(0, 255)), len, 1'b1);
                send_frame(f, 3);
            end else if (kind == 2) begin
                mk_frame(f, 8'($urandom_range(0, 255)), len, 1'b1);
                k = $urandom_range(1, f.size() - 1);
                foreach (f[i])
                    send_byte(f[i], (i == k) ? $urandom_range(TO - 3, TO + 2) : $urandom_range(0, 3),
                              ($urandom_range(0, 3) == 0));
            end else begin
                mk_frame(f, 8'($urandom_range(0, 255)), len, 1'b1);
                send_frame(f, 3);
            end
            wait_idle("random");
        end

        rmode = 0;
        wait_idle("final");
        chk("final_overrun_balance", ovr_exp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
